// File: rtl/store_write_buffer_if.sv
// Store-queue and memory-write handshake bundle for the store write buffer.
// The buffer uses the slave view; the store queue / memory side uses master.
interface store_write_buffer_if;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned MASK_W = DATA_W / 8;

   logic              store_req_valid;
   logic [ADDR_W-1:0] store_req_addr;
   logic [DATA_W-1:0] store_req_data;
   logic [MASK_W-1:0] store_req_byte_mask;
   logic              store_req_accepted;

   logic              mem_req_valid;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [DATA_W-1:0] mem_req_data;
   logic [MASK_W-1:0] mem_req_byte_mask;
   logic              mem_req_ready;
   logic              mem_ack;

   modport master (
      output store_req_valid, store_req_addr, store_req_data, store_req_byte_mask,
      input  store_req_accepted,
      input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_byte_mask,
      output mem_req_ready, mem_ack
   );

   modport slave (
      input  store_req_valid, store_req_addr, store_req_data, store_req_byte_mask,
      output store_req_accepted,
      output mem_req_valid, mem_req_addr, mem_req_data, mem_req_byte_mask,
      input  mem_req_ready, mem_ack
   );
endinterface

// File: rtl/store_write_buffer.sv
// Coalescing store write buffer: a circular FIFO of word-write entries that
// merges stores to the same unlocked word and drains one write at a time.
module store_write_buffer #(
   parameter int unsigned WB_DEPTH = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   store_write_buffer_if.slave       bus,
   output logic [$clog2(WB_DEPTH):0] wb_entries,
   output logic                      wb_empty
);

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned MASK_W  = DATA_W / 8;
   localparam int unsigned WADDR_W = ADDR_W - 2;
   localparam int unsigned IDX_W   = $clog2(WB_DEPTH);
   localparam int unsigned PTR_W   = IDX_W + 1;

   typedef struct packed {
      logic               valid;
      logic               locked;
      logic [WADDR_W-1:0] waddr;
      logic [DATA_W-1:0]  data;
      logic [MASK_W-1:0]  mask;
   } entry_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

   state_t             state;
   entry_t             entries     [WB_DEPTH];
   entry_t             entries_nxt [WB_DEPTH];
   entry_t             issue_entry;
   logic [PTR_W-1:0]   head, tail, count;
   logic [PTR_W-1:0]   head_nxt, tail_nxt, count_nxt;
   logic [IDX_W-1:0]   head_idx, tail_idx, scan_idx, hit_idx;
   logic [WADDR_W-1:0] store_waddr;
   logic               hit, full, accept, alloc, merge, pop, issue_start;

   logic               mem_valid_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic [DATA_W-1:0]  mem_data_q;
   logic [MASK_W-1:0]  mem_mask_q;

   // Byte offset is irrelevant: entries are tracked per word.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^bus.store_req_addr[1:0];

   assign store_waddr = bus.store_req_addr[ADDR_W-1:2];
   assign head_idx    = head[IDX_W-1:0];
   assign tail_idx    = tail[IDX_W-1:0];
   assign full        = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
   assign accept      = bus.store_req_valid && (hit || !full);
   assign alloc       = accept && !hit;
   assign merge       = accept && hit;
   assign pop         = (state == WAIT_ACK) && bus.mem_ack;

   assign bus.store_req_accepted = accept;
   assign bus.mem_req_valid      = mem_valid_q;
   assign bus.mem_req_addr       = mem_addr_q;
   assign bus.mem_req_data       = mem_data_q;
   assign bus.mem_req_byte_mask  = mem_mask_q;
   assign wb_entries             = count;

   // Merge lookup: scan oldest to youngest so the youngest match wins.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      scan_idx = '0;
      for (int k = 0; k < int'(WB_DEPTH); k++) begin
         scan_idx = head_idx + IDX_W'(k);
         if (entries[scan_idx].valid && !entries[scan_idx].locked &&
             entries[scan_idx].waddr == store_waddr) begin
            hit     = 1'b1;
            hit_idx = scan_idx;
         end
      end
   end

   // Next entry array and pointers; the entry about to be issued is locked here
   // so that the registered memory request always reflects its final contents.
   always_comb begin
      entries_nxt = entries;
      if (merge) begin
         for (int b = 0; b < int'(MASK_W); b++) begin
            if (bus.store_req_byte_mask[b]) begin
               entries_nxt[hit_idx].data[8*b +: 8] = bus.store_req_data[8*b +: 8];
            end
         end
         entries_nxt[hit_idx].mask = entries[hit_idx].mask | bus.store_req_byte_mask;
      end
      if (pop) begin
         entries_nxt[head_idx].valid  = 1'b0;
         entries_nxt[head_idx].locked = 1'b0;
      end
      if (alloc) begin
         entries_nxt[tail_idx] = '{valid:  1'b1,
                                   locked: 1'b0,
                                   waddr:  store_waddr,
                                   data:   bus.store_req_data,
                                   mask:   bus.store_req_byte_mask};
      end
      head_nxt    = head + PTR_W'(pop);
      tail_nxt    = tail + PTR_W'(alloc);
      count_nxt   = count + PTR_W'(alloc) - PTR_W'(pop);
      issue_start = ((state == IDLE) || pop) && (count_nxt != '0);
      if (issue_start) begin
         entries_nxt[head_nxt[IDX_W-1:0]].locked = 1'b1;
      end
      issue_entry = entries_nxt[head_nxt[IDX_W-1:0]];
   end

   // Entry storage, pointers and the drain FSM with registered request outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         entries     <= '{default: '0};
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         state       <= IDLE;
         wb_empty    <= 1'b1;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         mem_mask_q  <= '0;
      end else begin
         entries  <= entries_nxt;
         head     <= head_nxt;
         tail     <= tail_nxt;
         count    <= count_nxt;
         wb_empty <= (count_nxt == '0) && ((state == IDLE) || pop);
         case (state)
            IDLE: begin
               if (issue_start) begin
                  state       <= ISSUE;
                  mem_valid_q <= 1'b1;
                  mem_addr_q  <= {issue_entry.waddr, 2'b00};
                  mem_data_q  <= issue_entry.data;
                  mem_mask_q  <= issue_entry.mask;
               end
            end
            ISSUE: begin
               if (bus.mem_req_ready) begin
                  state       <= WAIT_ACK;
                  mem_valid_q <= 1'b0;
               end
            end
            WAIT_ACK: begin
               if (pop) begin
                  if (issue_start) begin
                     state       <= ISSUE;
                     mem_valid_q <= 1'b1;
                     mem_addr_q  <= {issue_entry.waddr, 2'b00};
                     mem_data_q  <= issue_entry.data;
                     mem_mask_q  <= issue_entry.mask;
                  end else begin
                     state      <= IDLE;
                     mem_addr_q <= '0;
                     mem_data_q <= '0;
                     mem_mask_q <= '0;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench for store_write_buffer: a reference queue of expected word
// writes is updated on every accepted store and compared on each memory write.
module tb_store_write_buffer;
   localparam int unsigned WB_DEPTH = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] wb_entries;
   logic       wb_empty;

   store_write_buffer_if bus();

   store_write_buffer #(.WB_DEPTH(WB_DEPTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .wb_entries (wb_entries),
      .wb_empty   (wb_empty)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [29:0] wa;
      logic [31:0] d;
      logic [3:0]  m;
   } exp_t;

   exp_t mdl[$];
   bit   waiting  = 1'b0;
   bit   last_acc = 1'b0;
   int   errors   = 0;
   int   checks   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, check against the model, then advance the model.
   task automatic tick(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [3:0] sm, input bit rdy, input bit ack, input bit rst);
      int   hit_i;
      bit   exp_valid;
      bit   hs;
      exp_t e;
      bus.store_req_valid     = sv;
      bus.store_req_addr      = sa;
      bus.store_req_data      = sd;
      bus.store_req_byte_mask = sm;
      bus.mem_req_ready       = rdy;
      bus.mem_ack             = ack;
      reset                   = rst;
      #1;
      hit_i = -1;
      for (int i = 1; i < mdl.size(); i++) begin
         if (mdl[i].wa == sa[31:2]) hit_i = i;
      end
      last_acc  = sv && ((hit_i > 0) || (mdl.size() < int'(WB_DEPTH)));
      exp_valid = (mdl.size() > 0) && !waiting;
      hs        = exp_valid && rdy;
      check("store_req_accepted", 64'(bus.store_req_accepted), 64'(last_acc));
      check("mem_req_valid", 64'(bus.mem_req_valid), 64'(exp_valid));
      check("wb_entries", 64'(wb_entries), 64'(mdl.size()));
      check("wb_empty", 64'(wb_empty), 64'(mdl.size() == 0));
      if (mdl.size() == 0) begin
         check("idle_addr_mask", 64'({bus.mem_req_addr, bus.mem_req_byte_mask}), 64'd0);
         check("idle_data", 64'(bus.mem_req_data), 64'd0);
      end
      if (hs) begin
         check("wr_addr", 64'(bus.mem_req_addr), 64'({mdl[0].wa, 2'b00}));
         check("wr_data", 64'(bus.mem_req_data), 64'(mdl[0].d));
         check("wr_mask", 64'(bus.mem_req_byte_mask), 64'(mdl[0].m));
      end
      @(posedge clock);
      if (rst) begin
         mdl.delete();
         waiting = 1'b0;
      end else begin
         if (last_acc) begin
            if (hit_i > 0) begin
               e = mdl[hit_i];
               for (int b = 0; b < 4; b++) begin
                  if (sm[b]) e.d[8*b +: 8] = sd[8*b +: 8];
               end
               e.m = e.m | sm;
               mdl[hit_i] = e;
            end else begin
               e.wa = sa[31:2];
               e.d  = sd;
               e.m  = sm;
               mdl.push_back(e);
            end
         end
         if (ack && waiting) begin
            void'(mdl.pop_front());
            waiting = 1'b0;
         end
         if (hs) waiting = 1'b1;
      end
      @(negedge clock);
   endtask

   task automatic store(input logic [31:0] sa, input logic [31:0] sd, input logic [3:0] sm,
                        input bit rdy, input bit ack);
      tick(1'b1, sa, sd, sm, rdy, ack, 1'b0);
   endtask

   task automatic idle(input bit rdy, input bit ack);
      tick(1'b0, 32'd0, 32'd0, 4'd0, rdy, ack, 1'b0);
   endtask

   task automatic drain();
      for (int n = 0; n < 64 && mdl.size() > 0; n++) idle(1'b1, waiting);
      idle(1'b0, 1'b0);
   endtask

   initial begin
      bus.store_req_valid     = 1'b0;
      bus.store_req_addr      = '0;
      bus.store_req_data      = '0;
      bus.store_req_byte_mask = '0;
      bus.mem_req_ready       = 1'b0;
      bus.mem_ack             = 1'b0;
      reset                   = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Single store: ready two cycles after the request, ack three cycles later.
      store(32'h1004, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0);
      idle(1'b0, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b0);

      // Coalescing behind an outstanding write.
      store(32'h2000, 32'h01020304, 4'hF, 1'b0, 1'b0);
      idle(1'b1, 1'b0);
      store(32'h3000, 32'h00001122, 4'h3, 1'b0, 1'b0);
      store(32'h3002, 32'h33440000, 4'hC, 1'b0, 1'b0);
      idle(1'b0, 1'b0);
      drain();

      // Same word as a locked, issuing head allocates a second entry.
      store(32'h4000, 32'h11111111, 4'hF, 1'b0, 1'b0);
      idle(1'b0, 1'b0);
      store(32'h4000, 32'h22222222, 4'h3, 1'b0, 1'b0);
      idle(1'b0, 1'b0);
      drain();

      // Full buffer, back-pressure until the cycle after the first ack, then wrap.
      store(32'h5000, 32'hA0000000, 4'hF, 1'b1, 1'b0);
      store(32'h5004, 32'hA0000001, 4'hF, 1'b1, 1'b0);
      store(32'h5008, 32'hA0000002, 4'hF, 1'b1, 1'b0);
      store(32'h500C, 32'hA0000003, 4'hF, 1'b1, 1'b0);
      repeat (3) store(32'h5010, 32'hA0000004, 4'hF, 1'b1, 1'b0);
      store(32'h5010, 32'hA0000004, 4'hF, 1'b1, 1'b1);
      store(32'h5010, 32'hA0000004, 4'hF, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         for (int t = 0; t < 16; t++) begin
            store(32'h6000 + 32'(4 * i), $urandom, 4'hF, 1'b1, waiting);
            if (last_acc) break;
         end
      end
      drain();

      // Reset while waiting for an ack with three entries, then a stray ack.
      store(32'h7000, 32'hB0000000, 4'hF, 1'b1, 1'b0);
      store(32'h7004, 32'hB0000001, 4'hF, 1'b1, 1'b0);
      store(32'h7008, 32'hB0000002, 4'hF, 1'b0, 1'b0);
      tick(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b0);

      // Random traffic over a small address window, including stray acks.
      for (int n = 0; n < 400; n++) begin
         tick(1'($urandom_range(0, 1)),
              32'h8000 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3)),
              $urandom, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)),
              waiting ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 7) == 0),
              1'b0);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
